rxtx_fifo_bridge: RTL and testbench
===================================

RXTX_FIFO_BRIDGE -- requirements
Module: rxtx_fifo_bridge

Interface
REQ-001 Parameter DW, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 16: FIFO entries, power of two, legal range 2..256.
REQ-003 Parameter AW = $clog2(DEPTH): derived, not overridable.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rxd  input  DW  receive data, sampled when rx_dv=1.
REQ-007 rx_dv  input  1  receive data valid, one word per cycle.
REQ-008 tx_rdy  input  1  downstream ready; transfer occurs when tx_en=1 and tx_rdy=1.
REQ-009 txd  output  DW  transmit data, registered.
REQ-010 tx_en  output  1  transmit data valid, registered.
REQ-011 full  output  1  FIFO storage holds DEPTH entries.
REQ-012 empty  output  1  FIFO storage holds 0 entries.
REQ-013 level  output  AW+1  FIFO storage occupancy, 0..DEPTH; excludes the output register.
REQ-014 ovf  output  1  sticky overflow flag.
REQ-015 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-016 Write: rx_dv=1 and full=0 at a clock edge SHALL store rxd at the write pointer and increment it.
REQ-017 Drop: rx_dv=1 and full=1 SHALL discard rxd and set ovf at that edge; a same-cycle pop SHALL NOT make room for that word.
REQ-018 Output register load condition: empty=0 and (tx_en=0 or tx_rdy=1); on load, txd takes the read-pointer word, tx_en=1, and the read pointer increments.
REQ-019 When tx_en=1, tx_rdy=1 and empty=1, tx_en SHALL go 0 at that edge; txd SHALL hold its last value.
REQ-020 When tx_en=1 and tx_rdy=0, txd and tx_en SHALL hold unchanged.
REQ-021 Latency: a word written at edge k into an empty FIFO with an idle output register SHALL appear with tx_en=1 after edge k+1 (2-cycle rxd-to-txd latency).
REQ-022 Throughput: with tx_rdy held at 1 and continuous rx_dv, the block SHALL pass one word per cycle without drops.
REQ-023 Ordering: words SHALL leave in arrival order, with no duplication and no loss other than REQ-017 drops.
REQ-024 Pointers: AW-bit pointers SHALL wrap from DEPTH-1 to 0; full and empty SHALL be derived from an AW+1-bit occupancy count or an extra wrap bit.
REQ-025 Simultaneous write and pop with 0<level<DEPTH SHALL leave level unchanged.
REQ-026 full, empty and level SHALL be registered and consistent with each other on every cycle.
REQ-027 ovf_clr=1 SHALL clear ovf; if a drop occurs in the same cycle, set SHALL win.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear both pointers, level=0, empty=1, full=0, tx_en=0, txd=0 and ovf=0; all statistics counters SHALL also clear.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; FIFO memory contents need not be cleared.
REQ-030 After rst_n deasserts, the first rx_dv SHALL be accepted on the first clock edge.

Configuration
REQ-031 Macro RXTX_FIFO_BRIDGE_STATS_EN SHALL gate the statistics feature.
REQ-032 With RXTX_FIFO_BRIDGE_STATS_EN defined, the block SHALL add three output ports:
  - rx_cnt (32 bits): accepted writes, wraps at 2^32.
  - tx_cnt (32 bits): completed transfers, wraps at 2^32.
  - drop_cnt (16 bits): dropped words, saturates at 16'hFFFF.
  All three SHALL count on the same edge as the counted event.
REQ-033 Without the macro, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then a single word 8'hA5 with tx_rdy=1 -> tx_en=1 and txd=8'hA5 exactly 2 edges after the write; level returns to 0.
REQ-035 Hold tx_rdy=0 and write 18 words 0..17 (DEPTH=16) -> first word waits in the output register; full=1 at level=16; word 17 dropped; ovf=1; drop_cnt=1 (STATS build); the next 16 txd transfers are 1..16 in order after tx_rdy=1.
REQ-036 Continuous writes of 0..99 with tx_rdy=1 -> 100 transfers in order; level never exceeds 1; ovf=0.
REQ-037 Random tx_rdy with rx_dv at 50% duty for 10000 cycles -> scoreboard matches in-order output; rx_cnt = tx_cnt + level + tx_en at the end.
REQ-038 Assert rst_n=0 with level=7 and tx_en=1 -> all outputs take reset values immediately, without waiting for a clock edge; no stale word appears after release.
REQ-039 ovf_clr=1 in the same cycle as a drop -> ovf stays 1; ovf_clr=1 on a later cycle with no drop -> ovf becomes 0.

Source files
------------

// File: rtl/rxtx_fifo_bridge_if.sv
// rtl/rxtx_fifo_bridge_if.sv - receive/transmit stream bundle for rxtx_fifo_bridge
interface rxtx_fifo_bridge_if #(
  parameter int DW = 8
);
  logic [DW-1:0] rxd;
  logic          rx_dv;
  logic          tx_rdy;
  logic [DW-1:0] txd;
  logic          tx_en;

  modport master (
    output rxd, rx_dv, tx_rdy,
    input  txd, tx_en
  );

  modport slave (
    input  rxd, rx_dv, tx_rdy,
    output txd, tx_en
  );
endinterface

// File: rtl/rxtx_fifo_bridge.sv
// rtl/rxtx_fifo_bridge.sv - FIFO bridge with registered output stage and sticky overflow
// Optional statistics counters enabled by RXTX_FIFO_BRIDGE_STATS_EN.
module rxtx_fifo_bridge #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rxtx_fifo_bridge_if.slave        bus,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef RXTX_FIFO_BRIDGE_STATS_EN
  ,
  output logic [31:0]              rx_cnt,
  output logic [31:0]              tx_cnt,
  output logic [15:0]              drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          drop;
  logic          load;
  logic          xfer;
  logic [AW:0]   level_nxt;

  // Acceptance looks only at the registered full flag, so a same-cycle pop never frees room.
  always_comb begin
    push      = bus.rx_dv && !full;
    drop      = bus.rx_dv && full;
    load      = !empty && (!bus.tx_en || bus.tx_rdy);
    xfer      = bus.tx_en && bus.tx_rdy;
    level_nxt = level;
    if (push && !load)
      level_nxt = level + LVL_ONE;
    else if (!push && load)
      level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.rxd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      bus.txd    <= '0;
      bus.tx_en  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (load) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        bus.txd   <= mem[rd_ptr];
        bus.tx_en <= 1'b1;
      end else if (xfer) begin
        bus.tx_en <= 1'b0;
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

`ifdef RXTX_FIFO_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (push)
        rx_cnt <= rx_cnt + 32'd1;
      if (xfer)
        tx_cnt <= tx_cnt + 32'd1;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rxtx_fifo_bridge.sv
// tb/tb_rxtx_fifo_bridge.sv - directed and scoreboard bench for rxtx_fifo_bridge
module tb_rxtx_fifo_bridge;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       ovf;
  logic       ovf_clr = 1'b0;
`ifdef RXTX_FIFO_BRIDGE_STATS_EN
  logic [31:0] rx_cnt;
  logic [31:0] tx_cnt;
  logic [15:0] drop_cnt;
`endif

  rxtx_fifo_bridge_if #(.DW(DW)) bus ();

  rxtx_fifo_bridge #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`ifdef RXTX_FIFO_BRIDGE_STATS_EN
    ,
    .rx_cnt  (rx_cnt),
    .tx_cnt  (tx_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       rdy;
    logic       en;
    logic [7:0] txd;
    logic [4:0] lvl;
  } vec_t;

  vec_t vt[15];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus.rx_dv  = 1'b0;
    bus.rxd    = '0;
    bus.tx_rdy = 1'b0;
    ovf_clr    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic dv, logic [7:0] d, logic rdy, logic en, logic [7:0] txd,
                              logic [4:0] lvl);
    vec_t v;
    v.dv = dv; v.d = d; v.rdy = rdy; v.en = en; v.txd = txd; v.lvl = lvl;
    return v;
  endfunction

  initial begin
    logic [7:0] sb[$];
    logic [7:0] w;
    int         exp_w;
    int         n_xfer;
    int         n_acc;
    int         max_lvl;
    int         m_lvl;
    logic       m_en;
    logic       m_push;
    logic       m_load;
    logic       ok;

    //             dv  rxd    rdy  tx_en txd    level
    vt[0]  = mk(1, 8'hA5, 1, 0, 8'h00, 5'd1);
    vt[1]  = mk(0, 8'h00, 1, 1, 8'hA5, 5'd0);
    vt[2]  = mk(0, 8'h00, 1, 0, 8'hA5, 5'd0);
    vt[3]  = mk(1, 8'h11, 0, 0, 8'hA5, 5'd1);
    vt[4]  = mk(1, 8'h22, 0, 1, 8'h11, 5'd1);
    vt[5]  = mk(1, 8'h33, 0, 1, 8'h11, 5'd2);
    vt[6]  = mk(0, 8'h00, 0, 1, 8'h11, 5'd2);
    vt[7]  = mk(0, 8'h00, 1, 1, 8'h22, 5'd1);
    vt[8]  = mk(0, 8'h00, 1, 1, 8'h33, 5'd0);
    vt[9]  = mk(0, 8'h00, 1, 0, 8'h33, 5'd0);
    vt[10] = mk(1, 8'h44, 1, 0, 8'h33, 5'd1);
    vt[11] = mk(1, 8'h55, 1, 1, 8'h44, 5'd1);
    vt[12] = mk(1, 8'h66, 1, 1, 8'h55, 5'd1);
    vt[13] = mk(0, 8'h00, 1, 1, 8'h66, 5'd0);
    vt[14] = mk(0, 8'h00, 1, 0, 8'h66, 5'd0);

    do_reset();
    chk("reset_state", 32'({bus.tx_en, bus.txd, level, full, empty, ovf}),
        32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0}));

    for (int i = 0; i < 15; i++) begin
      bus.rx_dv  = vt[i].dv;
      bus.rxd    = vt[i].d;
      bus.tx_rdy = vt[i].rdy;
      step();
      chk($sformatf("vec%0d", i), 32'({bus.tx_en, bus.txd, level, full, empty, ovf}),
          32'({vt[i].en, vt[i].txd, vt[i].lvl, vt[i].lvl == 5'd16, vt[i].lvl == 5'd0, 1'b0}));
    end
    bus.rx_dv = 1'b0;

    // Fill with output stalled: word 0 parks in the output register, 1..16 fill storage, 17 drops.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      bus.rx_dv = 1'b1;
      bus.rxd   = 8'(i);
      step();
      chk($sformatf("fill%0d", i), 32'({level, full, ovf}),
          32'({5'((i == 0) ? 1 : (i > 16 ? 16 : i)), i >= 16, i == 17}));
    end
    chk("fill_outreg", 32'({bus.tx_en, bus.txd}), 32'({1'b1, 8'h00}));
    bus.rxd = 8'h99;
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    bus.rx_dv = 1'b0;
    step();
    chk("ovf_clear", 32'(ovf), 32'd0);
    ovf_clr = 1'b0;
`ifdef RXTX_FIFO_BRIDGE_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd2);
`endif
    bus.tx_rdy = 1'b1;
    exp_w = 0;
    for (int c = 0; c < 40 && exp_w <= 16; c++) begin
      if (bus.tx_en) begin
        chk($sformatf("drain%0d", exp_w), 32'(bus.txd), 32'(exp_w));
        exp_w++;
      end
      step();
    end
    chk("drain_count", 32'(exp_w), 32'd17);
    chk("drain_idle", 32'({bus.tx_en, level, empty}), 32'({1'b0, 5'd0, 1'b1}));

    // Streaming at full rate must never back up past one stored word.
    do_reset();
    bus.tx_rdy = 1'b1;
    sb.delete();
    n_xfer  = 0;
    max_lvl = 0;
    ok      = 1'b1;
    for (int c = 0; c < 110; c++) begin
      bus.rx_dv = (c < 100);
      bus.rxd   = 8'(c);
      if (bus.tx_en) begin
        if (sb.size() == 0) ok = 1'b0;
        else begin
          w = sb.pop_front();
          if (bus.txd !== w) ok = 1'b0;
        end
        n_xfer++;
      end
      if (c < 100) sb.push_back(8'(c));
      step();
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    chk("stream_order", 32'(ok), 32'd1);
    chk("stream_count", 32'(n_xfer), 32'd100);
    chk("stream_max_level", 32'(max_lvl), 32'd1);
    chk("stream_ovf", 32'(ovf), 32'd0);

    // Random traffic against a cycle model that decides acceptance independently of the DUT.
    do_reset();
    sb.delete();
    m_lvl  = 0;
    m_en   = 1'b0;
    n_acc  = 0;
    n_xfer = 0;
    ok     = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      bus.rx_dv  = 1'($urandom_range(0, 1));
      bus.rxd    = 8'($urandom_range(0, 255));
      bus.tx_rdy = 1'($urandom_range(0, 1));
      if (bus.tx_en !== m_en) ok = 1'b0;
      if (bus.tx_en && bus.tx_rdy) begin
        if (sb.size() == 0) ok = 1'b0;
        else begin
          w = sb.pop_front();
          if (bus.txd !== w) ok = 1'b0;
        end
        n_xfer++;
      end
      m_push = bus.rx_dv && (m_lvl < DEPTH);
      m_load = (m_lvl > 0) && (!m_en || bus.tx_rdy);
      if (m_push) begin
        sb.push_back(bus.rxd);
        n_acc++;
      end
      step();
      m_lvl = m_lvl + (m_push ? 1 : 0) - (m_load ? 1 : 0);
      if (m_load) m_en = 1'b1;
      else if (m_en && bus.tx_rdy) m_en = 1'b0;
    end
    bus.rx_dv  = 1'b0;
    bus.tx_rdy = 1'b0;
    chk("rand_order", 32'(ok), 32'd1);
    chk("rand_level", 32'(level), 32'(m_lvl));
    chk("rand_balance", 32'(n_acc), 32'(n_xfer + int'(level) + int'(bus.tx_en)));
`ifdef RXTX_FIFO_BRIDGE_STATS_EN
    chk("rand_rx_cnt", rx_cnt, 32'(n_acc));
    chk("rand_tx_cnt", tx_cnt, 32'(n_xfer));
`endif

    // Asynchronous reset in the middle of a clock period.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.rx_dv = 1'b1;
      bus.rxd   = 8'(8'h80 + i);
      step();
    end
    bus.rx_dv = 1'b0;
    chk("pre_reset", 32'({bus.tx_en, level}), 32'({1'b1, 5'd7}));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({bus.tx_en, bus.txd, level, full, empty, ovf}),
        32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0}));
    step();
    rst_n      = 1'b1;
    bus.tx_rdy = 1'b1;
    ok         = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.tx_en !== 1'b0 || level !== 5'd0) ok = 1'b0;
    end
    chk("no_stale_after_reset", 32'(ok), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
